// File: rtl/gen_share_arbiter.sv
// rtl/gen_share_arbiter.sv - round-robin sharing of one start/valid/done generator among NUM_REQ callers
// The grant pulse is visible in LOAD; gen_start is raised in the first RUN cycle.
module gen_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
) (
  input  logic                     _clock,
  input  logic                     _reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_base,
  input  logic [NUM_REQ*WIDTH-1:0] req_limit,
  input  logic [NUM_REQ*WIDTH-1:0] req_step,
  output logic [NUM_REQ-1:0]       req_grant,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [NUM_REQ-1:0]       rsp_done,
  output logic [WIDTH-1:0]         rsp_out0,
  output logic [WIDTH-1:0]         rsp_out1,
  output logic                     gen_start,
  output logic [WIDTH-1:0]         gen_base,
  output logic [WIDTH-1:0]         gen_limit,
  output logic [WIDTH-1:0]         gen_step,
  output logic                     gen_ready,
  input  logic                     gen_valid,
  input  logic                     gen_done,
  input  logic [WIDTH-1:0]         gen_out0,
  input  logic [WIDTH-1:0]         gen_out1
);

  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t          state;
  logic [SW-1:0]   ptr;
  logic [SW-1:0]   sel;
  logic [SW-1:0]   pick;
  logic [SW-1:0]   ptr_next;
  logic            any;

  // Walk from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    int unsigned idx;
    idx  = 0;
    pick = '0;
    any  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        pick = SW'(idx);
        any  = 1'b1;
      end
    end
  end

  assign ptr_next = SW'((int'(sel) + 1) % NUM_REQ);

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      req_grant <= '0;
      gen_start <= 1'b0;
      gen_base  <= '0;
      gen_limit <= '0;
      gen_step  <= '0;
    end else begin
      req_grant <= '0;
      gen_start <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            sel       <= pick;
            gen_base  <= req_base[pick*WIDTH +: WIDTH];
            gen_limit <= req_limit[pick*WIDTH +: WIDTH];
            gen_step  <= req_step[pick*WIDTH +: WIDTH];
            req_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
            state     <= LOAD;
          end
        end
        LOAD: begin
          gen_start <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (gen_done) begin
            ptr   <= ptr_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Generator outputs reach only the granted requester, and only while RUN.
  always_comb begin
    rsp_valid = '0;
    rsp_done  = '0;
    gen_ready = 1'b0;
    if (state == RUN) begin
      rsp_valid[sel] = gen_valid;
      rsp_done[sel]  = gen_done;
      gen_ready      = rsp_ready[sel];
    end
  end

  assign rsp_out0 = gen_out0;
  assign rsp_out1 = gen_out1;

endmodule
